// File: rtl/button_debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package button_debounce_pkg;

  localparam int SYNC_STAGES = 2;

  // clog2(n), floored at 1 so that a 2-cycle period still has a 1-bit counter.
  function automatic int cnt_width(input longint unsigned n);
    int w;
    w = 0;
    while ((64'd1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchronizer for one asynchronous bit, synchronous active-low reset to 0.
module sync_2ff
  import button_debounce_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounces one mechanical push-button into a stable registered level.
// Define BUTTON_DEBOUNCE_PULSE_EN to add a one-cycle button_press pulse on each press.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int CLK_FREQ        = 95_000,
  parameter int DEBOUNCE_PER_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic button_valid
`ifdef BUTTON_DEBOUNCE_PULSE_EN
  ,
  output logic button_press
`endif
);

  localparam int DEB_CYCLES = CLK_FREQ * DEBOUNCE_PER_MS;
  localparam int CNT_W      = cnt_width(longint'(DEB_CYCLES));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2) begin : g_bad_period
    $error("button_debounce: DEB_CYCLES must be at least 2");
  end

  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_in),
    .q   (sync_q2)
  );

  // Any sample matching the current output restarts the run, so only an
  // unbroken DEB_CYCLES-long disagreement flips the output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      button_valid <= 1'b0;
    end else if (sync_q2 == button_valid) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      button_valid <= sync_q2;
      cnt          <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef BUTTON_DEBOUNCE_PULSE_EN
  logic valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      button_press <= 1'b0;
    end else begin
      valid_q      <= button_valid;
      button_press <= button_valid & ~valid_q;
    end
  end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with a 100-cycle debounce period.
module tb_button_debounce;

  localparam int DEB = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button_in = 1'b0;
  logic button_valid;
`ifdef BUTTON_DEBOUNCE_PULSE_EN
  logic button_press;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_debounce #(.CLK_FREQ(100), .DEBOUNCE_PER_MS(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .button_in    (button_in),
    .button_valid (button_valid)
`ifdef BUTTON_DEBOUNCE_PULSE_EN
    ,
    .button_press (button_press)
`endif
  );

  // Reference: the synchronized level is the raw input two edges late; the
  // output takes a new level once the last DEB synchronized samples since
  // reset all disagree with it.
  bit s_d1, s_d2, m_valid, m_valid_q, m_press;
  bit win[$];

  always @(posedge clk) begin : model
    bit s;
    bit all_diff;
    if (!rst) begin
      s_d1 = 0; s_d2 = 0; win.delete();
      m_valid = 0; m_valid_q = 0; m_press = 0;
    end else begin
      s = s_d2; s_d2 = s_d1; s_d1 = button_in;
      win.push_back(s);
      if (win.size() > DEB) void'(win.pop_front());
      m_press = m_valid & ~m_valid_q;
      m_valid_q = m_valid;
      all_diff = (win.size() == DEB);
      foreach (win[i]) if (win[i] == m_valid) all_diff = 0;
      if (all_diff) m_valid = s;
    end
  end

  task automatic test_reset();
    int lat;
    rst = 1'b0; button_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (button_valid !== 1'b0) begin
        failures++; $display("FAIL reset_hold cyc=%0d valid=%b expected=0", c, button_valid);
      end
    end
    rst = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      checks++;
      if (button_valid !== m_valid) begin
        failures++; $display("FAIL reset_model cyc=%0d valid=%b expected=%b", lat, button_valid, m_valid);
      end
    end while (button_valid !== 1'b1 && lat < 300);
    checks++;
    if (lat != DEB + 2) begin
      failures++; $display("FAIL reset_latency got=%0d expected=%0d", lat, DEB + 2);
    end
  endtask

  task automatic test_press_bounce();
    int per[4] = '{2, 10, 16, 20};
    int lat;
    button_in = 1'b0;
    for (int c = 0; c < DEB + 10; c++) @(negedge clk);
    checks++;
    if (button_valid !== 1'b0) begin
      failures++; $display("FAIL press_start valid=%b expected=0", button_valid);
    end
    foreach (per[p]) begin
      for (int h = 0; h < 2; h++) begin
        button_in = (h == 0);
        for (int c = 0; c < per[p]; c++) begin
          @(negedge clk);
          checks++;
          if (button_valid !== 1'b0 || m_valid !== 1'b0) begin
            failures++; $display("FAIL press_bounce per=%0d valid=%b model=%b expected=0", per[p], button_valid, m_valid);
          end
        end
      end
    end
    button_in = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      checks++;
      if (button_valid !== m_valid) begin
        failures++; $display("FAIL press_model cyc=%0d valid=%b expected=%b", lat, button_valid, m_valid);
      end
    end while (button_valid !== 1'b1 && lat < 300);
    checks++;
    if (lat != DEB + 2) begin
      failures++; $display("FAIL press_latency got=%0d expected=%0d", lat, DEB + 2);
    end
  endtask

  task automatic test_release_bounce();
    int per[4] = '{2, 10, 16, 20};
    int lat;
    button_in = 1'b1;
    for (int c = 0; c < DEB + 10; c++) @(negedge clk);
    checks++;
    if (button_valid !== 1'b1) begin
      failures++; $display("FAIL release_start valid=%b expected=1", button_valid);
    end
    foreach (per[p]) begin
      for (int h = 0; h < 2; h++) begin
        button_in = (h != 0);
        for (int c = 0; c < per[p]; c++) begin
          @(negedge clk);
          checks++;
          if (button_valid !== 1'b1 || m_valid !== 1'b1) begin
            failures++; $display("FAIL release_bounce per=%0d valid=%b model=%b expected=1", per[p], button_valid, m_valid);
          end
        end
      end
    end
    button_in = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      checks++;
      if (button_valid !== m_valid) begin
        failures++; $display("FAIL release_model cyc=%0d valid=%b expected=%b", lat, button_valid, m_valid);
      end
    end while (button_valid !== 1'b0 && lat < 300);
    checks++;
    if (lat != DEB + 2) begin
      failures++; $display("FAIL release_latency got=%0d expected=%0d", lat, DEB + 2);
    end
  endtask

  task automatic test_boundary();
    int lat;
    int rise_at;
    button_in = 1'b0;
    for (int c = 0; c < DEB + 10; c++) @(negedge clk);
    // 99-cycle pulse must be swallowed
    button_in = 1'b1;
    for (int c = 0; c < DEB - 1; c++) @(negedge clk);
    button_in = 1'b0;
    for (int c = 0; c < 2 * DEB; c++) begin
      @(negedge clk);
      checks++;
      if (button_valid !== 1'b0) begin
        failures++; $display("FAIL boundary_99 cyc=%0d valid=%b expected=0", c, button_valid);
      end
    end
    // 100-cycle pulse must get through, then release after another 102
    button_in = 1'b1;
    rise_at = -1;
    for (int c = 1; c <= DEB; c++) begin
      @(negedge clk);
      if (button_valid === 1'b1 && rise_at < 0) rise_at = c;
    end
    button_in = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (button_valid === 1'b1 && rise_at < 0) rise_at = DEB + lat;
    end while (!(rise_at >= 0 && button_valid === 1'b0) && lat < 400);
    checks++;
    if (rise_at != DEB + 2) begin
      failures++; $display("FAIL boundary_100_rise got=%0d expected=%0d", rise_at, DEB + 2);
    end
    checks++;
    if (lat != DEB + 2) begin
      failures++; $display("FAIL boundary_100_fall got=%0d expected=%0d", lat, DEB + 2);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    button_in = 1'b0;
    for (int c = 0; c < DEB + 10; c++) @(negedge clk);
    button_in = 1'b1;
    for (int c = 0; c < 52; c++) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (button_valid !== 1'b0) begin
        failures++; $display("FAIL mid_reset_hold cyc=%0d valid=%b expected=0", c, button_valid);
      end
    end
    rst = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      checks++;
      if (button_valid !== m_valid) begin
        failures++; $display("FAIL mid_reset_model cyc=%0d valid=%b expected=%b", lat, button_valid, m_valid);
      end
    end while (button_valid !== 1'b1 && lat < 300);
    checks++;
    if (lat != DEB + 2) begin
      failures++; $display("FAIL mid_reset_latency got=%0d expected=%0d", lat, DEB + 2);
    end
  endtask

  task automatic test_random();
    bit lvl;
    int len;
    for (int seg = 0; seg < 40; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 160));
      button_in = lvl;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        checks++;
        if (button_valid !== m_valid) begin
          failures++; $display("FAIL random seg=%0d cyc=%0d valid=%b expected=%b", seg, c, button_valid, m_valid);
        end
      end
    end
  endtask

`ifdef BUTTON_DEBOUNCE_PULSE_EN
  task automatic test_pulse();
    int pulses;
    int rel_pulses;
    button_in = 1'b0;
    for (int c = 0; c < DEB + 10; c++) @(negedge clk);
    pulses = 0; rel_pulses = 0;
    for (int k = 0; k < 2; k++) begin
      for (int h = 0; h < 2; h++) begin
        button_in = (h == 0);
        for (int c = 0; c < DEB + 30; c++) begin
          @(negedge clk);
          if (button_press === 1'b1) begin
            if (h == 0) pulses++; else rel_pulses++;
          end
          checks++;
          if (button_press !== m_press) begin
            failures++; $display("FAIL pulse_model k=%0d cyc=%0d press=%b expected=%b", k, c, button_press, m_press);
          end
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++; $display("FAIL pulse_count got=%0d expected=2", pulses);
    end
    checks++;
    if (rel_pulses != 0) begin
      failures++; $display("FAIL pulse_on_release got=%0d expected=0", rel_pulses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press_bounce();
    test_release_bounce();
    test_boundary();
    test_mid_reset();
    test_random();
`ifdef BUTTON_DEBOUNCE_PULSE_EN
    test_pulse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
